dsp_chain_sop2_acc: RTL and testbench
=====================================

DSP_CHAIN_SOP2_ACC -- requirements
Module: dsp_chain_sop2_acc

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of chained sum-of-2-products stages (legal 1..16).
REQ-002 SHALL have parameter DATA_W, default 8, signed two's-complement operand width.
REQ-003 SHALL have parameter ACC_W, default 32, signed chain and accumulator width (legal ACC_W >= 2*DATA_W+2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand beat offered.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_last  input  1  marks final beat of one accumulation group.
REQ-009 SHALL have ports top_a, top_b, bot_a, bot_b  input  NUM_STAGES*DATA_W each  stage i uses slice [i*DATA_W +: DATA_W].
REQ-010 SHALL have port out_valid  output  1  result holds a completed group sum.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port result  output  ACC_W  signed group sum.
REQ-013 SHALL have port sat_flag  output  1  at least one saturation occurred in the group.

Function
REQ-014 Stage i SHALL compute chain_i = chain_(i-1) + top_a_i*top_b_i + bot_a_i*bot_b_i (signed, sign-extended to ACC_W), chain_(-1) = 0, registered once per stage.
REQ-015 Stage i operands SHALL pass through an i-cycle skew delay so that all stage slices of one beat combine into one chain value.
REQ-016 A valid bit and last bit SHALL travel with each beat through the skew/chain pipeline; bubbles SHALL NOT alter accumulator state.
REQ-017 The accumulator stage SHALL add each valid chain output into acc; on a beat with last=1 it SHALL load result with acc+chain, set out_valid, and clear acc to 0 in the same cycle.
REQ-018 Latency from acceptance of the last beat to out_valid high SHALL be exactly NUM_STAGES+1 cycles when not stalled.
REQ-019 Global enable SHALL be !(out_valid && !out_ready); when low every pipeline, skew, valid and accumulator register SHALL hold.
REQ-020 in_ready SHALL equal global enable.
REQ-021 out_valid SHALL clear on out_valid && out_ready unless a new group completes in that same cycle, in which case result/out_valid SHALL reload with the new group.
REQ-022 result and sat_flag SHALL remain stable while out_valid && !out_ready.
REQ-023 Back-to-back groups (in_last every beat) SHALL sustain one result per cycle with out_ready held high.
REQ-024 Arithmetic without saturation SHALL wrap modulo 2^ACC_W.

Reset
REQ-025 On reset, all valid/last bits, chain registers, acc, result SHALL be 0, out_valid 0, sat_flag 0.
REQ-026 Reset mid-group SHALL discard partial sums and in-flight beats; the next accepted beat starts a new group.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 With macro DSP_CHAIN_SAT_EN defined, every chain adder and the accumulator SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and sat_flag SHALL be sticky per group, captured with result.
REQ-029 Without DSP_CHAIN_SAT_EN, adders SHALL wrap per REQ-024 and sat_flag SHALL be tied to 0.

Verification
REQ-030 Defaults; one beat, all slices top_a=1,top_b=2,bot_a=3,bot_b=4, in_last=1 -> out_valid exactly 5 cycles after accept, result=56.
REQ-031 Defaults; 3 beats of REQ-030 operands, last on third -> single result=168, no output for first two beats.
REQ-032 Defaults; one beat all operands -128, last=1 -> result=131072, sat_flag=0.
REQ-033 ACC_W=18; REQ-032 stimulus -> with DSP_CHAIN_SAT_EN result=131071, sat_flag=1; without, result=-131072, sat_flag=0.
REQ-034 Back-to-back single-beat groups with out_ready low 3 cycles after first result -> in_ready low those cycles, result held at 56, all later results delivered in order, none lost or duplicated.
REQ-035 Reset asserted 2 cycles after accepting beat 1 of a 2-beat group, then REQ-030 beat -> only result=56 appears.

Source files
------------

// File: rtl/dsp_chain_sop2_acc.sv
// Chained sum-of-two-products stages with skewed operands, feeding a group accumulator.
// Optional macro DSP_CHAIN_SAT_EN makes every adder saturate and enables sat_flag reporting.
module dsp_chain_sop2_acc #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [NUM_STAGES*DATA_W-1:0] top_a,
  input  logic [NUM_STAGES*DATA_W-1:0] top_b,
  input  logic [NUM_STAGES*DATA_W-1:0] bot_a,
  input  logic [NUM_STAGES*DATA_W-1:0] bot_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             result,
  output logic                         sat_flag
);

  logic             en;
  logic             in_v_q;
  logic             in_l_q;
  logic [ACC_W-1:0] chain_w [NUM_STAGES];
  logic             v_w     [NUM_STAGES];
  logic             l_w     [NUM_STAGES];
  logic             s_w     [NUM_STAGES];
  logic [ACC_W-1:0] acc;
  logic             acc_sat;
  logic [ACC_W:0]   acc_sum;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Returns {overflow_flag, sum}; the flag can only be set in the saturating build.
  function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y);
    logic [ACC_W:0] r;
`ifdef DSP_CHAIN_SAT_EN
    logic [ACC_W:0] full;
    full = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    if (full[ACC_W] != full[ACC_W-1])
      r = {1'b1, full[ACC_W], {(ACC_W-1){~full[ACC_W]}}};
    else
      r = {1'b0, full[ACC_W-1:0]};
`else
    r = {1'b0, x + y};
`endif
    return r;
  endfunction

  function automatic logic signed [2*DATA_W:0] sx(input logic [DATA_W-1:0] v);
    return {{(DATA_W+1){v[DATA_W-1]}}, v};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      in_v_q <= 1'b0;
      in_l_q <= 1'b0;
    end else if (en) begin
      in_v_q <= in_valid;
      in_l_q <= in_last;
    end
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    // sk[0] is the shared input register; stage i consumes its slice i cycles later.
    logic [4*DATA_W-1:0]      sk [i+1];
    logic [ACC_W-1:0]         chain_q;
    logic [ACC_W-1:0]         prev;
    logic                     v_q, l_q, s_q;
    logic                     pv, pl, ps;
    logic [DATA_W-1:0]        ta, tb, ba, bb;
    logic signed [2*DATA_W:0] sop;
    logic [ACC_W-1:0]         sop_x;
    logic [ACC_W:0]           sum;

    assign {ta, tb, ba, bb} = sk[i];
    assign sop   = sx(ta) * sx(tb) + sx(ba) * sx(bb);
    assign sop_x = {{(ACC_W-2*DATA_W-1){sop[2*DATA_W]}}, sop};

    if (i == 0) begin : g_head
      assign prev = '0;
      assign pv   = in_v_q;
      assign pl   = in_l_q;
      assign ps   = 1'b0;
    end else begin : g_link
      assign prev = chain_w[i-1];
      assign pv   = v_w[i-1];
      assign pl   = l_w[i-1];
      assign ps   = s_w[i-1];
    end

    assign sum = add_sat(prev, sop_x);

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) sk[k] <= '0;
        chain_q <= '0;
        v_q     <= 1'b0;
        l_q     <= 1'b0;
        s_q     <= 1'b0;
      end else if (en) begin
        sk[0] <= {top_a[i*DATA_W +: DATA_W], top_b[i*DATA_W +: DATA_W],
                  bot_a[i*DATA_W +: DATA_W], bot_b[i*DATA_W +: DATA_W]};
        for (int k = 1; k <= i; k++) sk[k] <= sk[k-1];
        chain_q <= sum[ACC_W-1:0];
        v_q     <= pv;
        l_q     <= pl;
        s_q     <= ps | sum[ACC_W];
      end
    end

    assign chain_w[i] = chain_q;
    assign v_w[i]     = v_q;
    assign l_w[i]     = l_q;
    assign s_w[i]     = s_q;
  end

  assign acc_sum = add_sat(acc, chain_w[NUM_STAGES-1]);

  // Completing a group loads result and restarts acc in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      acc_sat   <= 1'b0;
      result    <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (v_w[NUM_STAGES-1]) begin
        if (l_w[NUM_STAGES-1]) begin
          result    <= acc_sum[ACC_W-1:0];
          sat_flag  <= acc_sat | s_w[NUM_STAGES-1] | acc_sum[ACC_W];
          out_valid <= 1'b1;
          acc       <= '0;
          acc_sat   <= 1'b0;
        end else begin
          acc       <= acc_sum[ACC_W-1:0];
          acc_sat   <= acc_sat | s_w[NUM_STAGES-1] | acc_sum[ACC_W];
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_chain_sop2_acc.sv
// Table-driven scoreboard bench for dsp_chain_sop2_acc (default instance plus an ACC_W=18 instance).
module tb_dsp_chain_sop2_acc;

  typedef struct {
    logic [31:0]        ta, tb, ba, bb;
    logic               last;
    logic signed [31:0] expv;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] top_a = '0, top_b = '0, bot_a = '0, bot_b = '0;
  logic        in_ready, out_valid, sat_flag;
  logic [31:0] result;

  logic        sel18 = 1'b0;
  logic        in_valid2;
  logic        in_ready2, out_valid2, sat_flag2;
  logic [17:0] result2;
  int          cnt2 = 0;
  logic [17:0] res2_cap = '0;
  logic        sat2_cap = 1'b0;

  int   n_vec = 0;
  int   n_mis = 0;
  exp_t sbq[$];
  vec_t tbl [10];

  always #5 clk = ~clk;
  assign in_valid2 = in_valid & sel18;

  dsp_chain_sop2_acc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .top_a(top_a), .top_b(top_b), .bot_a(bot_a), .bot_b(bot_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .sat_flag(sat_flag)
  );

  dsp_chain_sop2_acc #(.NUM_STAGES(4), .DATA_W(8), .ACC_W(18)) dut18 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_last(in_last),
    .top_a(top_a), .top_b(top_b), .bot_a(bot_a), .bot_b(bot_b),
    .out_valid(out_valid2), .out_ready(1'b1), .result(result2), .sat_flag(sat_flag2)
  );

  function automatic logic [31:0] rep(input logic [7:0] v);
    return {4{v}};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, $signed(act), act, $signed(expv), expv);
    end
  endtask

  // Drives one beat and holds it until the handshake; returns right after the accepting edge.
  task automatic apply_stimulus(input vec_t v);
    int tries = 0;
    @(negedge clk);
    top_a = v.ta; top_b = v.tb; bot_a = v.ba; bot_b = v.bb;
    in_last = v.last; in_valid = 1'b1;
    forever begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        if (v.last) sbq.push_back('{res: v.expv, sat: 1'b0});
        break;
      end
      tries++;
      if (tries > 50) begin
        n_vec++; n_mis++;
        $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: compares every delivered result against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_vec++; n_mis++;
          $display("[TB] FAIL unexpected_result: got %0d, expected no output", $signed(result));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check_output("result", result, e.res);
          check_output("sat_flag", {31'b0, sat_flag}, {31'b0, e.sat});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid2) begin
        cnt2++;
        res2_cap = result2;
        sat2_cap = sat_flag2;
      end
    end
  end

  initial begin
    vec_t v;
    tbl[0] = '{rep(8'd1), rep(8'd2), rep(8'd3), rep(8'd4), 1'b1, 56};
    tbl[1] = '{rep(8'h80), rep(8'h80), rep(8'h80), rep(8'h80), 1'b1, 131072};
    tbl[2] = '{32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0};
    tbl[3] = '{rep(8'd127), rep(8'd127), rep(8'h80), rep(8'd127), 1'b1, -508};
    tbl[4] = '{32'h04030201, 32'h08070605, 32'hFCFDFEFF, 32'h01010101, 1'b1, 60};
    tbl[5] = '{rep(8'd127), rep(8'd127), rep(8'd127), rep(8'd127), 1'b1, 129032};
    tbl[6] = '{rep(8'h80), rep(8'd127), rep(8'h80), rep(8'd127), 1'b1, -130048};
    tbl[7] = '{rep(8'd1), rep(8'd2), rep(8'd3), rep(8'd4), 1'b0, 0};
    tbl[8] = '{rep(8'd1), rep(8'd2), rep(8'd3), rep(8'd4), 1'b0, 0};
    tbl[9] = '{rep(8'd1), rep(8'd2), rep(8'd3), rep(8'd4), 1'b1, 168};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("reset_result", result, 32'd0);
    check_output("reset_sat_flag", {31'b0, sat_flag}, 32'd0);
    check_output("reset_in_ready", {31'b0, in_ready}, 32'd1);

    // Latency: out_valid must rise exactly five cycles after the accepting edge.
    apply_stimulus(tbl[0]);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("latency_c%0d", k), {31'b0, out_valid}, (k == 5) ? 32'd1 : 32'd0);
    end
    idle(3);

    for (int i = 0; i < 10; i++) apply_stimulus(tbl[i]);
    idle(15);

    sel18 = 1'b1;
    apply_stimulus(tbl[1]);
    idle(1);
    sel18 = 1'b0;
    idle(12);
    check_output("acc18_count", cnt2, 32'd1);
`ifdef DSP_CHAIN_SAT_EN
    check_output("acc18_result", {14'b0, res2_cap}, 32'h1FFFF);
    check_output("acc18_sat", {31'b0, sat2_cap}, 32'd1);
`else
    check_output("acc18_result", {14'b0, res2_cap}, 32'h20000);
    check_output("acc18_sat", {31'b0, sat2_cap}, 32'd0);
`endif

    // Back-to-back single-beat groups with a three-cycle downstream stall on the first result.
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          v = '{rep(8'(k + 1)), rep(8'd2), rep(8'd3), rep(8'd4), 1'b1, 4 * (2 * (k + 1) + 12)};
          apply_stimulus(v);
        end
        idle(1);
      end
      begin
        int waited = 0;
        forever begin
          @(negedge clk);
          if (out_valid) break;
          waited++;
          if (waited > 40) break;
        end
        if (!out_valid) begin
          n_vec++; n_mis++;
          $display("[TB] FAIL stall_wait: got out_valid=0, expected 1 within 40 cycles");
        end else begin
          out_ready = 1'b0;
          for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check_output($sformatf("stall_in_ready_c%0d", c), {31'b0, in_ready}, 32'd0);
            check_output($sformatf("stall_result_c%0d", c), result, 32'd56);
          end
          @(negedge clk);
          out_ready = 1'b1;
        end
      end
    join
    idle(15);

    // Reset in the middle of a two-beat group; only the following single-beat group may emerge.
    v = '{rep(8'd1), rep(8'd2), rep(8'd3), rep(8'd4), 1'b0, 0};
    apply_stimulus(v);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(tbl[0]);
    idle(15);

    check_output("scoreboard_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
